// File: rtl/dmem_bytelane.sv
// -----------------------------------------------------------------------------
// dmem_bytelane
//   RISC-V data memory for the datapath memory stage. Supports byte, halfword
//   and word loads/stores selected by funct3, with sign or zero extension on
//   loads. Base address and depth are configurable. An optional sweep zeroes
//   every word after reset. A sticky fault register records the first
//   misaligned, out-of-range or illegal-funct3 access.
//
// Parameters
//   DATA_WIDTH     : data width (only 32 is supported)
//   DEPTH          : number of 32-bit words (power of two, >= 4)
//   BASE_ADDR      : byte address of word 0 (DEPTH*4 aligned)
//   CLEAR_ON_RESET : 1 = zero all words after reset, 0 = ready immediately
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   WE          in   store enable
//   RE          in   load enable (qualifies read fault logging only)
//   funct3      in   access size: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   A           in   byte address
//   WD          in   store data, right-aligned
//   RD          out  load data, extended, combinational
//   ready       out  high once the clear sweep has finished
//   fault       out  sticky error flag
//   fault_cause out  01 misaligned, 10 out of range, 11 illegal funct3
//   fault_addr  out  address of the first faulting access
//   fault_clr   in   clears fault, fault_cause and fault_addr
// -----------------------------------------------------------------------------
module dmem_bytelane #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DEPTH          = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_2000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  WE,
    input  logic                  RE,
    input  logic [2:0]            funct3,
    input  logic [31:0]           A,
    input  logic [DATA_WIDTH-1:0] WD,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  ready,
    output logic                  fault,
    output logic [1:0]            fault_cause,
    output logic [31:0]           fault_addr,
    input  logic                  fault_clr
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_MISAL = 2'b01;
    localparam logic [1:0] CAUSE_RANGE = 2'b10;
    localparam logic [1:0] CAUSE_ILL   = 2'b11;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_q;
    logic [AW-1:0]   cnt_q;
    logic [31:0]     mem_q [DEPTH];

    logic            fault_q,       fault_d;
    logic [1:0]      fault_cause_q, fault_cause_d;
    logic [31:0]     fault_addr_q,  fault_addr_d;

    // ------------------------------------------------------------------
    // Address decode and access checks
    // ------------------------------------------------------------------
    logic [31:0]     offset;
    logic            in_range;
    logic            f3_legal;
    logic            misaligned;
    logic [1:0]      cause;
    logic            err;
    logic [AW-1:0]   idx;

    // A below BASE_ADDR wraps the offset past SPAN, so one unsigned compare
    // covers both range limits.
    assign offset   = A - BASE_ADDR;
    assign in_range = ({1'b0, offset} < SPAN);
    assign idx      = offset[AW+1:2];

    always_comb begin
        f3_legal   = 1'b0;
        misaligned = 1'b0;
        unique case (funct3)
            F3_B, F3_BU: f3_legal = 1'b1;
            F3_H, F3_HU: begin
                f3_legal   = 1'b1;
                misaligned = A[0];
            end
            F3_W: begin
                f3_legal   = 1'b1;
                misaligned = (A[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

    always_comb begin
        cause = CAUSE_NONE;
        if (!in_range) begin
            cause = CAUSE_RANGE;
        end else if (!f3_legal) begin
            cause = CAUSE_ILL;
        end else if (misaligned) begin
            cause = CAUSE_MISAL;
        end
    end

    assign err   = (cause != CAUSE_NONE);
    assign ready = (state_q == ST_READY);

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    logic [31:0] rword;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_ext;

    assign rword  = mem_q[idx];
    assign byte_v = rword[{A[1:0], 3'b000} +: 8];
    assign half_v = rword[{A[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = '0;
        unique case (funct3)
            F3_B:    load_ext = {{24{byte_v[7]}}, byte_v};
            F3_BU:   load_ext = {24'h0, byte_v};
            F3_H:    load_ext = {{16{half_v[15]}}, half_v};
            F3_HU:   load_ext = {16'h0, half_v};
            F3_W:    load_ext = rword;
            default: load_ext = '0;
        endcase
    end

    assign RD = (ready && !err) ? DATA_WIDTH'(load_ext) : '0;

    // ------------------------------------------------------------------
    // Store path: replicate the right-aligned data across lanes and let
    // the byte enables pick which lanes land.
    // ------------------------------------------------------------------
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        store_en;

    always_comb begin
        wdata = '0;
        be    = '0;
        unique case (funct3[1:0])
            2'b00: begin
                wdata = {4{WD[7:0]}};
                be    = 4'b0001 << A[1:0];
            end
            2'b01: begin
                wdata = {2{WD[15:0]}};
                be    = A[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                wdata = WD[31:0];
                be    = 4'b1111;
            end
            default: ;
        endcase
    end

    assign store_en = WE && ready && !err;

    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (store_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Clear sweep FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_READY;
                    end
                end
                ST_READY: ;
                default:  state_q <= RESET_STATE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky fault register. A new error in the same cycle as fault_clr
    // is captured as the first error rather than being cleared.
    // ------------------------------------------------------------------
    logic log_en;

    assign log_en = (WE || RE) && ready && err;

    always_comb begin
        fault_d       = fault_q;
        fault_cause_d = fault_cause_q;
        fault_addr_d  = fault_addr_q;
        if (log_en) begin
            fault_d = 1'b1;
            if (!fault_q || fault_clr) begin
                fault_cause_d = cause;
                fault_addr_d  = A;
            end
        end else if (fault_clr) begin
            fault_d       = 1'b0;
            fault_cause_d = CAUSE_NONE;
            fault_addr_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q       <= 1'b0;
            fault_cause_q <= CAUSE_NONE;
            fault_addr_q  <= '0;
        end else begin
            fault_q       <= fault_d;
            fault_cause_q <= fault_cause_d;
            fault_addr_q  <= fault_addr_d;
        end
    end

    assign fault       = fault_q;
    assign fault_cause = fault_cause_q;
    assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_dmem_bytelane.sv
module tb_dmem_bytelane;

    logic        clk;
    logic        rst_n;
    logic        WE;
    logic        RE;
    logic [2:0]  funct3;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        ready;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_addr;
    logic        fault_clr;

    int n_cmp;
    int n_bad;

    dmem_bytelane #(
        .DATA_WIDTH    (32),
        .DEPTH         (16),
        .BASE_ADDR     (32'h0000_2000),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .WE         (WE),
        .RE         (RE),
        .funct3     (funct3),
        .A          (A),
        .WD         (WD),
        .RD         (RD),
        .ready      (ready),
        .fault      (fault),
        .fault_cause(fault_cause),
        .fault_addr (fault_addr),
        .fault_clr  (fault_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic        clr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_fault;
        logic [1:0]  exp_cause;
        logic [31:0] exp_addr;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic we, input logic re, input logic clr,
                                input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] exp_rd,
                                input logic exp_fault, input logic [1:0] exp_cause,
                                input logic [31:0] exp_addr);
        vec_t v;
        v.we = we; v.re = re; v.clr = clr; v.f3 = f3; v.a = a; v.wd = wd;
        v.exp_rd = exp_rd; v.exp_fault = exp_fault;
        v.exp_cause = exp_cause; v.exp_addr = exp_addr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        WE = 1'b0; RE = 1'b0; fault_clr = 1'b0;
        funct3 = 3'b010; A = 32'h2000; WD = '0;
    endtask

    // Counts rising edges until ready rises, bounded.
    task automatic wait_ready(input string name, input int exp_edges, input logic sweep_stim);
        int cyc;
        cyc = 0;
        while (!ready && cyc < 40) begin
            if (sweep_stim) begin
                WE = 1'b1; RE = 1'b1; funct3 = 3'b010; WD = 32'hFFFF_FFFF;
                A  = cyc[0] ? 32'h2006 : 32'h2004;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        idle();
        check(name, 32'(cyc), 32'(exp_edges));
    endtask

    task automatic check_all_zero(input string name);
        for (int w = 0; w < 16; w++) begin
            RE = 1'b1; funct3 = 3'b010; A = 32'h2000 + 32'(w * 4);
            #1;
            check($sformatf("%s word%0d", name, w), RD, 32'h0);
        end
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        idle();

        // Filled as: we re clr f3 a wd | exp_rd fault cause addr
        vecs[0]  = mk(1,0,0,3'b010,32'h2004,32'hDEADBEEF, 32'h00000000, 0,2'b00,32'h0);
        vecs[1]  = mk(1,0,0,3'b000,32'h2005,32'h0000005A, 32'hFFFFFFBE, 0,2'b00,32'h0);
        vecs[2]  = mk(0,1,0,3'b010,32'h2004,32'h0,        32'hDEAD5AEF, 0,2'b00,32'h0);
        vecs[3]  = mk(0,1,0,3'b000,32'h2005,32'h0,        32'h0000005A, 0,2'b00,32'h0);
        vecs[4]  = mk(0,1,0,3'b100,32'h2007,32'h0,        32'h000000DE, 0,2'b00,32'h0);
        vecs[5]  = mk(0,1,0,3'b000,32'h2007,32'h0,        32'hFFFFFFDE, 0,2'b00,32'h0);
        vecs[6]  = mk(1,0,0,3'b001,32'h2002,32'h12348001, 32'h00000000, 0,2'b00,32'h0);
        vecs[7]  = mk(0,1,0,3'b001,32'h2002,32'h0,        32'hFFFF8001, 0,2'b00,32'h0);
        vecs[8]  = mk(0,1,0,3'b101,32'h2002,32'h0,        32'h00008001, 0,2'b00,32'h0);
        vecs[9]  = mk(0,1,0,3'b010,32'h2000,32'h0,        32'h80010000, 0,2'b00,32'h0);
        vecs[10] = mk(1,0,0,3'b010,32'h2006,32'hFFFFFFFF, 32'h00000000, 1,2'b01,32'h2006);
        vecs[11] = mk(0,1,0,3'b010,32'h2004,32'h0,        32'hDEAD5AEF, 1,2'b01,32'h2006);
        vecs[12] = mk(0,1,0,3'b010,32'h1FFC,32'h0,        32'h00000000, 1,2'b01,32'h2006);
        vecs[13] = mk(0,1,1,3'b010,32'h2040,32'h0,        32'h00000000, 1,2'b10,32'h2040);
        vecs[14] = mk(0,0,1,3'b010,32'h2000,32'h0,        32'h80010000, 0,2'b00,32'h0);
        vecs[15] = mk(0,1,0,3'b011,32'h2000,32'h0,        32'h00000000, 1,2'b11,32'h2000);
        vecs[16] = mk(0,0,1,3'b010,32'h2000,32'h0,        32'h80010000, 0,2'b00,32'h0);
        vecs[17] = mk(0,1,0,3'b010,32'h203C,32'h0,        32'h00000000, 0,2'b00,32'h0);
        vecs[18] = mk(1,1,0,3'b010,32'h203C,32'hCAFEF00D, 32'h00000000, 0,2'b00,32'h0);
        vecs[19] = mk(0,1,0,3'b010,32'h203C,32'h0,        32'hCAFEF00D, 0,2'b00,32'h0);
        vecs[20] = mk(0,1,0,3'b001,32'h2001,32'h0,        32'h00000000, 1,2'b01,32'h2001);
        vecs[21] = mk(0,1,0,3'b010,32'h2040,32'h0,        32'h00000000, 1,2'b01,32'h2001);
        vecs[22] = mk(0,0,1,3'b010,32'h203C,32'h0,        32'hCAFEF00D, 0,2'b00,32'h0);
        vecs[23] = mk(0,0,0,3'b010,32'h2041,32'h0,        32'h00000000, 0,2'b00,32'h0);
        vecs[24] = mk(0,1,0,3'b000,32'h2003,32'h0,        32'hFFFFFF80, 0,2'b00,32'h0);
        vecs[25] = mk(1,0,0,3'b111,32'h1FFC,32'h11111111, 32'h00000000, 1,2'b10,32'h1FFC);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst ready",       32'(ready),       32'h0);
        check("rst fault",       32'(fault),       32'h0);
        check("rst fault_cause", 32'(fault_cause), 32'h0);
        check("rst fault_addr",  fault_addr,       32'h0);
        check("rst RD",          RD,               32'h0);

        // Release; stores (one aligned, one misaligned) during the sweep
        // must be ignored and must not log a fault.
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("sweep edges", 16, 1'b1);
        check("sweep fault", 32'(fault), 32'h0);
        @(negedge clk);
        check_all_zero("post-sweep");

        // Directed vectors
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            WE = vecs[i].we; RE = vecs[i].re; fault_clr = vecs[i].clr;
            funct3 = vecs[i].f3; A = vecs[i].a; WD = vecs[i].wd;
            #2;
            check($sformatf("v%0d RD", i), RD, vecs[i].exp_rd);
            @(posedge clk);
            #1;
            idle();
            check($sformatf("v%0d fault", i),       32'(fault),       32'(vecs[i].exp_fault));
            check($sformatf("v%0d fault_cause", i), 32'(fault_cause), 32'(vecs[i].exp_cause));
            check($sformatf("v%0d fault_addr", i),  fault_addr,       vecs[i].exp_addr);
        end

        // Asynchronous reset clears the fault register immediately
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst2 ready", 32'(ready), 32'h0);
        check("rst2 fault", 32'(fault), 32'h0);
        check("rst2 addr",  fault_addr, 32'h0);

        // Reset pulsed mid-sweep restarts the full sweep
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("mid-sweep ready", 32'(ready), 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("restart edges", 16, 1'b0);
        @(negedge clk);
        check_all_zero("post-restart");
        check("post-restart fault", 32'(fault), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
